rr_ring_arbiter: RTL
====================

Name: rr_ring_arbiter

Overview:
Round-robin arbiter that shares one resource among N requesters. Priority comes from a one-hot rotating pointer, which is the same ring-counter sequence used elsewhere in the design (0001→0010→0100→1000→0001). A grant is held until the requester releases it or a hold limit expires. A fixed idle gap follows every grant. The arbiter sits between the requesting units and the shared datapath, and it drives the datapath select.

Parameters:
N, 4, number of requesters (≥2)
MAX_HOLD, 8, maximum cycles one grant may stay asserted (≥1)
GAP_CYCLES, 1, idle cycles with no grant after each release or revoke (≥1)

Ports:
clk  input  1  clock; all state updates on falling edge
rst  input  1  reset, synchronous, active-high
req  input  N  per-requester request level; held high while the resource is wanted
grant  output  N  one-hot grant, or all-zero
grant_id  output  $clog2(N)  binary index of the granted requester; holds last value when grant=0
busy  output  1  high exactly when grant≠0
timeout  output  1  one-cycle pulse when a grant is revoked at MAX_HOLD
ptr  output  N  one-hot priority pointer; ptr bit = highest priority

Behaviour:
- Timing: all registers update on negedge clk. Every output is registered.
- Reset (rst=1 at an edge) loads: state=IDLE, grant=0, grant_id=0, busy=0, timeout=0, ptr=1 (bit0), hold and gap counters=0. Reset overrides everything, including mid-grant; grant drops at that same edge.
- Selection function:
  - Scan req starting at the ptr bit, then upward with wrap (bit N-1 wraps to bit 0).
  - The first set bit wins.
  - If req=0, nothing is selected.
- IDLE state:
  - At each edge, if req≠0: grant=winner, grant_id=index, hold=1, go to GRANT.
  - Latency: req high before edge k gives grant visible after edge k.
- GRANT state, at each edge, evaluated in this order:
  1. req[grant_id]=0 → release. grant=0, ptr=rotate-left(one-hot of grant_id), gap=1, go to GAP.
  2. Otherwise, hold=MAX_HOLD → revoke. Same actions as release, plus timeout=1 for this cycle only.
  3. Otherwise, hold=hold+1 and the grant is unchanged.
- Consequences of that order:
  - grant is high for at most MAX_HOLD cycles.
  - A release on the same edge as the limit is a normal release, with no timeout.
- Counter widths: hold counter is $clog2(MAX_HOLD+1) bits and never wraps. Gap counter is $clog2(GAP_CYCLES+1) bits.
- Requests from other requesters during GRANT are ignored.
- GAP state:
  - grant=0 throughout.
  - At an edge with gap<GAP_CYCLES: gap=gap+1.
  - At an edge with gap=GAP_CYCLES: run the selection function with the updated ptr. If a winner exists, grant it (hold=1, go to GRANT). Otherwise go to IDLE.
  - Result: exactly GAP_CYCLES grant-free cycles between consecutive grants.
- ptr changes only on release or revoke. ptr is always exactly one-hot. The rotate-left wraps bit N-1 to bit 0.
- A revoked requester that keeps req high is still eligible; it simply has the lowest priority after the rotation.
- Invariants:
  - grant is one-hot or zero.
  - busy == |grant.
  - timeout never asserts when grant was released normally.

Test Plan:
- Reset: rst=1 for 2 edges, with req=1111 throughout. Required: grant=0, busy=0, ptr=0001, timeout=0. Release rst with req=0100: grant=0100, grant_id=2 after the first non-reset edge.
- Basic and gap: ptr=0001, req=0101. Required: grant=0001. Drop req[0]: at that edge grant=0, ptr=0010. After 1 gap cycle: grant=0100, grant_id=2.
- Fairness and wrap: req=1111 held. Each granted requester drops its req 3 cycles after its grant, then re-raises it during the gap. Required grant order: 0001, 0010, 0100, 1000, 0001. ptr after the 4th release = 0001.
- Timeout: only req[2]=1, held continuously. Required:
  - grant=0100 for exactly 8 cycles.
  - Then grant=0 with timeout=1 for one cycle, and ptr=1000.
  - After the gap, grant=0100 again.
  - No timeout pulse on any other cycle.
- Release at the limit: req[1] drops on the edge where hold=MAX_HOLD. Required: normal release, timeout stays 0, ptr=0100.
- Reset mid-grant: grant=1000 active, assert rst for one edge. Required at that edge: grant=0, ptr=0001, state IDLE. With req=1001 still high, the next edge grants 0001.

Source files
------------

// File: rtl/rr_ring_arbiter.sv
// rr_ring_arbiter: round-robin arbiter sharing one resource among N requesters.
// Priority follows a one-hot rotating pointer. A grant lasts until its requester
// drops req or MAX_HOLD cycles elapse (revoke, with a one-cycle timeout pulse).
// Every grant is followed by GAP_CYCLES grant-free cycles. All state changes
// on the falling clock edge, and every output is registered.
//
// Ports:
//   clk      clock, falling-edge active
//   rst      synchronous active-high reset
//   req      per-requester request levels
//   grant    one-hot grant or zero
//   grant_id binary index of the current/last grant
//   busy     high exactly when grant is non-zero
//   timeout  one-cycle pulse on a revoke at MAX_HOLD
//   ptr      one-hot priority pointer (set bit = highest priority)
module rr_ring_arbiter #(
   parameter int unsigned N          = 4,
   parameter int unsigned MAX_HOLD   = 8,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_id,
   output logic                 busy,
   output logic                 timeout,
   output logic [N-1:0]         ptr
);

   localparam int unsigned IdW   = $clog2(N);
   localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
   localparam int unsigned GapW  = $clog2(GAP_CYCLES + 1);

   localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);
   localparam logic [GapW-1:0]  GapMax  = GapW'(GAP_CYCLES);

   typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

   state_e           state_q, state_d;
   logic [N-1:0]     grant_q, grant_d;
   logic [IdW-1:0]   id_q, id_d;
   logic             busy_q, busy_d;
   logic             timeout_q, timeout_d;
   logic [N-1:0]     ptr_q, ptr_d;
   logic [HoldW-1:0] hold_q, hold_d;
   logic [GapW-1:0]  gap_q, gap_d;

   // Selection: first set req bit scanning upward from the ptr bit, with wrap.
   logic           sel_found;
   logic [IdW-1:0] sel_idx;
   logic [N-1:0]   sel_oh;

   always_comb begin
      int p_idx;
      int j;
      p_idx     = 0;
      j         = 0;
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_oh    = '0;
      for (int i = 0; i < N; i++) begin
         if (ptr_q[i]) p_idx = i;
      end
      for (int i = 0; i < N; i++) begin
         j = (p_idx + i) % N;
         if (!sel_found && req[j]) begin
            sel_found = 1'b1;
            sel_idx   = IdW'(j);
         end
      end
      for (int i = 0; i < N; i++) begin
         sel_oh[i] = sel_found && (sel_idx == IdW'(i));
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      id_d      = id_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      gap_d     = gap_q;
      timeout_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (sel_found) begin
               grant_d = sel_oh;
               id_d    = sel_idx;
               hold_d  = HoldW'(1);
               state_d = StGrant;
            end
         end
         StGrant: begin
            // Release takes precedence over revoke when both happen on one edge.
            if (!req[id_q] || (hold_q == HoldMax)) begin
               grant_d   = '0;
               // grant_q is one-hot of id_q, so rotating it rotates the pointer.
               ptr_d     = {grant_q[N-2:0], grant_q[N-1]};
               gap_d     = GapW'(1);
               timeout_d = req[id_q];
               state_d   = StGap;
            end else begin
               hold_d = hold_q + HoldW'(1);
            end
         end
         StGap: begin
            if (gap_q != GapMax) begin
               gap_d = gap_q + GapW'(1);
            end else if (sel_found) begin
               grant_d = sel_oh;
               id_d    = sel_idx;
               hold_d  = HoldW'(1);
               state_d = StGrant;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d = |grant_d;
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         grant_q   <= '0;
         id_q      <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
         ptr_q     <= N'(1);
         hold_q    <= '0;
         gap_q     <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         id_q      <= id_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         gap_q     <= gap_d;
      end
   end

   assign grant    = grant_q;
   assign grant_id = id_q;
   assign busy     = busy_q;
   assign timeout  = timeout_q;
   assign ptr      = ptr_q;

endmodule
